// File: rtl/top_level_pkg.sv
// Shared types and constants for the UART-driven SIMON 32/64 encryptor.
// Imported by top_level and simon32_64_core.
package top_level_pkg;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_KEY,
    ST_TEXT,
    ST_ENC,
    ST_SEND
  } state_e;

  localparam int WORD_W       = 16;
  localparam int SIMON_ROUNDS = 32;
  localparam int ROUND_W      = $clog2(SIMON_ROUNDS);

  localparam logic [7:0] CMD_SIMON = 8'h01;

  // Leftmost bit of the literal is sequence element 0.
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  function automatic logic z0_bit(input logic [5:0] idx);
    return Z0[6'd61 - idx];
  endfunction

endpackage

// File: rtl/simon32_64_core.sv
// Iterative SIMON 32/64 encryptor: one round per clock, round keys expanded on the fly.
// A start pulse loads key and text; done pulses once the ciphertext is ready on x_out/y_out.
module simon32_64_core
  import top_level_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [WORD_W-1:0]      x_in,
  input  logic [WORD_W-1:0]      y_in,
  input  logic [3:0][WORD_W-1:0] key_in,
  output logic                   done,
  output logic [WORD_W-1:0]      x_out,
  output logic [WORD_W-1:0]      y_out
);

  localparam logic [ROUND_W-1:0] RND_LAST = ROUND_W'(SIMON_ROUNDS - 1);

  logic [WORD_W-1:0]      x_q;
  logic [WORD_W-1:0]      y_q;
  logic [3:0][WORD_W-1:0] kw_q;
  logic [ROUND_W-1:0]     rnd_q;
  logic                   busy_q;
  logic [WORD_W-1:0]      x_nxt;
  logic [WORD_W-1:0]      k_new;

  function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] v, input int unsigned n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] v, input int unsigned n);
    return rol(v, WORD_W - n);
  endfunction

  function automatic logic [WORD_W-1:0] round_f(input logic [WORD_W-1:0] x,
                                                input logic [WORD_W-1:0] y,
                                                input logic [WORD_W-1:0] k);
    return y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k;
  endfunction

  function automatic logic [WORD_W-1:0] next_key(input logic [WORD_W-1:0] k0,
                                                 input logic [WORD_W-1:0] k1,
                                                 input logic [WORD_W-1:0] k3,
                                                 input logic              z);
    logic [WORD_W-1:0] t;
    t = ror(k3, 3) ^ k1;
    return ~k0 ^ t ^ ror(t, 1) ^ {{(WORD_W-1){1'b0}}, z} ^ WORD_W'(3);
  endfunction

  // kw_q always holds k[i..i+3] for the round i about to run.
  assign x_nxt = round_f(x_q, y_q, kw_q[0]);
  assign k_new = next_key(kw_q[0], kw_q[1], kw_q[3], z0_bit(6'(rnd_q)));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_q    <= '0;
      y_q    <= '0;
      kw_q   <= '0;
      rnd_q  <= '0;
      busy_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        x_q    <= x_in;
        y_q    <= y_in;
        kw_q   <= key_in;
        rnd_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        x_q   <= x_nxt;
        y_q   <= x_q;
        kw_q  <= {k_new, kw_q[3:1]};
        rnd_q <= rnd_q + ROUND_W'(1);
        if (rnd_q == RND_LAST) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign x_out = x_q;
  assign y_out = y_q;

endmodule

// File: rtl/top_level.sv
// UART front end and command FSM for the SIMON 32/64 encryptor (CMD -> KEY -> TEXT -> ENC -> SEND).
// Optional macro DATA_OUT_TEST_EN keeps a debug register of the last valid received byte.
module top_level
  import top_level_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rx_data,
  output logic       uart_tx_data,
  output logic       led_input_commande,
  output logic       led_key_input,
  output logic       led_text_input,
  output logic       led_wait_result,
  output logic       led_output_result,
  output logic [7:0] data_out_test
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_s1, rx_s2, rx_s3;
  logic             rx_busy;
  logic [3:0]       rx_bit_idx;
  logic [CNT_W-1:0] rx_clk_cnt;
  logic [7:0]       rx_shift;
  logic [7:0]       rx_byte;
  logic             rx_valid;

  logic             tx_active;
  logic             tx_load;
  logic             tx_done;
  logic [3:0]       tx_bit_idx;
  logic [CNT_W-1:0] tx_clk_cnt;
  logic [8:0]       tx_shift;
  logic [7:0]       tx_byte;
  logic [1:0]       tx_idx;

  state_e                 state, state_nxt;
  logic [2:0]             byte_cnt;
  logic [1:0]             send_cnt;
  logic [7:0]             lo_byte;
  logic [3:0][WORD_W-1:0] key_q;
  logic [WORD_W-1:0]      text_x;
  logic                   core_start;
  logic                   core_done;
  logic [WORD_W-1:0]      ct_x, ct_y;

  // Synchronizers reset high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx_data;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // rx_bit_idx: 0 = start-bit check, 1..8 = data bits, 9 = stop bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_busy    <= 1'b0;
      rx_bit_idx <= '0;
      rx_clk_cnt <= '0;
      rx_shift   <= '0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (rx_s3 && !rx_s2) begin
          rx_busy    <= 1'b1;
          rx_bit_idx <= '0;
          rx_clk_cnt <= '0;
        end
      end else if (rx_bit_idx == 4'd0) begin
        if (rx_clk_cnt == HALF_LAST) begin
          rx_clk_cnt <= '0;
          if (rx_s2) rx_busy <= 1'b0;
          else       rx_bit_idx <= 4'd1;
        end else begin
          rx_clk_cnt <= rx_clk_cnt + CNT_W'(1);
        end
      end else if (rx_clk_cnt != BIT_LAST) begin
        rx_clk_cnt <= rx_clk_cnt + CNT_W'(1);
      end else begin
        rx_clk_cnt <= '0;
        if (rx_bit_idx == 4'd9) begin
          rx_busy <= 1'b0;
          if (rx_s2) begin
            rx_valid <= 1'b1;
            rx_byte  <= rx_shift;
          end
        end else begin
          rx_shift   <= {rx_s2, rx_shift[7:1]};
          rx_bit_idx <= rx_bit_idx + 4'd1;
        end
      end
    end
  end

  // A load on the final stop-bit cycle chains the next byte with no idle gap.
  assign tx_done = tx_active && (tx_clk_cnt == BIT_LAST) && (tx_bit_idx == 4'd9);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      uart_tx_data <= 1'b1;
      tx_active    <= 1'b0;
      tx_bit_idx   <= '0;
      tx_clk_cnt   <= '0;
      tx_shift     <= '1;
    end else if (tx_load) begin
      uart_tx_data <= 1'b0;
      tx_active    <= 1'b1;
      tx_bit_idx   <= '0;
      tx_clk_cnt   <= '0;
      tx_shift     <= {1'b1, tx_byte};
    end else if (tx_active) begin
      if (tx_clk_cnt != BIT_LAST) begin
        tx_clk_cnt <= tx_clk_cnt + CNT_W'(1);
      end else begin
        tx_clk_cnt <= '0;
        if (tx_bit_idx == 4'd9) begin
          tx_active <= 1'b0;
        end else begin
          uart_tx_data <= tx_shift[0];
          tx_shift     <= {1'b1, tx_shift[8:1]};
          tx_bit_idx   <= tx_bit_idx + 4'd1;
        end
      end
    end
  end

  assign tx_idx = (state == ST_SEND) ? send_cnt + 2'd1 : 2'd0;

  always_comb begin
    tx_byte = '0;
    unique case (tx_idx)
      2'd0: tx_byte = ct_x[7:0];
      2'd1: tx_byte = ct_x[15:8];
      2'd2: tx_byte = ct_y[7:0];
      2'd3: tx_byte = ct_y[15:8];
      default: tx_byte = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_CMD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    tx_load    = 1'b0;
    unique case (state)
      ST_CMD:  if (rx_valid && rx_byte == CMD_SIMON) state_nxt = ST_KEY;
      ST_KEY:  if (rx_valid && byte_cnt == 3'd7) state_nxt = ST_TEXT;
      ST_TEXT: begin
        if (rx_valid && byte_cnt == 3'd3) begin
          state_nxt  = ST_ENC;
          core_start = 1'b1;
        end
      end
      ST_ENC: begin
        if (core_done) begin
          state_nxt = ST_SEND;
          tx_load   = 1'b1;
        end
      end
      ST_SEND: begin
        if (tx_done) begin
          if (send_cnt == 2'd3) state_nxt = ST_CMD;
          else                  tx_load   = 1'b1;
        end
      end
      default: state_nxt = ST_CMD;
    endcase
  end

  // Even byte_cnt holds the low byte; odd byte_cnt completes a word.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      byte_cnt <= '0;
      send_cnt <= '0;
      lo_byte  <= '0;
      key_q    <= '0;
      text_x   <= '0;
    end else begin
      if (rx_valid && (state == ST_KEY || state == ST_TEXT)) begin
        if (!byte_cnt[0])           lo_byte <= rx_byte;
        else if (state == ST_KEY)   key_q[byte_cnt[2:1]] <= {rx_byte, lo_byte};
        else if (!byte_cnt[1])      text_x <= {rx_byte, lo_byte};
        byte_cnt <= (state_nxt != state) ? 3'd0 : byte_cnt + 3'd1;
      end
      if (tx_load) send_cnt <= (state == ST_ENC) ? 2'd0 : send_cnt + 2'd1;
    end
  end

  // The last text byte feeds the core directly so encryption starts on its strobe.
  simon32_64_core u_core (
    .clk    (clk),
    .resetn (resetn),
    .start  (core_start),
    .x_in   (text_x),
    .y_in   ({rx_byte, lo_byte}),
    .key_in (key_q),
    .done   (core_done),
    .x_out  (ct_x),
    .y_out  (ct_y)
  );

  assign led_input_commande = (state == ST_CMD);
  assign led_key_input      = (state == ST_KEY);
  assign led_text_input     = (state == ST_TEXT);
  assign led_wait_result    = (state == ST_ENC);
  assign led_output_result  = (state == ST_SEND);

`ifdef DATA_OUT_TEST_EN
  logic [7:0] dbg_byte;

  always_ff @(posedge clk) begin
    if (!resetn)       dbg_byte <= '0;
    else if (rx_valid) dbg_byte <= rx_byte;
  end

  assign data_out_test = dbg_byte;
`else
  assign data_out_test = 8'h00;
`endif

endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: UART command/key/text load, SIMON 32/64 result, error and reset cases.
module tb_top_level;

  localparam int CLKS     = 16;
  localparam int TX_LIMIT = 6 * 10 * CLKS + 200;

  localparam logic [4:0] LED_CMD  = 5'b10000;
  localparam logic [4:0] LED_KEY  = 5'b01000;
  localparam logic [4:0] LED_TEXT = 5'b00100;
  localparam logic [4:0] LED_ENC  = 5'b00010;
  localparam logic [4:0] LED_SEND = 5'b00001;

  logic       clk;
  logic       resetn;
  logic       rx_line;
  logic       uart_tx_data;
  logic       led_input_commande, led_key_input, led_text_input;
  logic       led_wait_result, led_output_result;
  logic [7:0] data_out_test;

  logic [7:0] key_bytes  [8] = '{8'h00, 8'h01, 8'h08, 8'h09, 8'h10, 8'h11, 8'h18, 8'h19};
  logic [7:0] text_bytes [4] = '{8'h65, 8'h65, 8'h77, 8'h68};
  logic [7:0] exp_ct     [4] = '{8'h9B, 8'hC6, 8'hBB, 8'hE9};

  int n_vec  = 0;
  int n_miss = 0;

  int         cyc      = 0;
  int         rxv_cnt  = 0;
  int         last_rxv = 0;
  logic       tx_prev  = 1'b1;
  int         fall_q [$];
  logic [8:0] tx_q   [$];

  top_level #(.CLKS_PER_BIT(CLKS)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .uart_rx_data       (rx_line),
    .uart_tx_data       (uart_tx_data),
    .led_input_commande (led_input_commande),
    .led_key_input      (led_key_input),
    .led_text_input     (led_text_input),
    .led_wait_result    (led_wait_result),
    .led_output_result  (led_output_result),
    .data_out_test      (data_out_test)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (dut.rx_valid) begin
      rxv_cnt  <= rxv_cnt + 1;
      last_rxv <= cyc;
    end
    if (tx_prev === 1'b1 && uart_tx_data === 1'b0) fall_q.push_back(cyc);
    tx_prev <= uart_tx_data;
  end

  // UART receiver model: samples mid-bit, records {stop, data}.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (uart_tx_data === 1'b0) begin
        repeat (CLKS / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLKS) @(negedge clk);
          b[i] = uart_tx_data;
        end
        repeat (CLKS) @(negedge clk);
        tx_q.push_back({uart_tx_data, b});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] leds();
    return {led_input_commande, led_key_input, led_text_input, led_wait_result, led_output_result};
  endfunction

  function automatic logic [7:0] dot(input logic [7:0] b);
`ifdef DATA_OUT_TEST_EN
    return b;
`else
    return b & 8'h00;
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_line = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (CLKS) @(negedge clk);
    end
    rx_line = stop_bit;
    repeat (CLKS) @(negedge clk);
    rx_line = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_txn();
    send_byte(8'h01, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(key_bytes[i], 1'b1);
    for (int i = 0; i < 4; i++) send_byte(text_bytes[i], 1'b1);
  endtask

  task automatic wait_tx(input int base, input int n);
    int w = 0;
    while (tx_q.size() < base + n && w < TX_LIMIT) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic check_ct(input int base);
    logic [8:0] got;
    check_eq("tx_count", tx_q.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      got = (base + i < tx_q.size()) ? tx_q[base + i] : 9'h000;
      check_eq($sformatf("tx_byte%0d", i), got, {1'b1, exp_ct[i]});
    end
  endtask

  initial begin
    int base, fb, rxv0, lat;
    resetn  = 1'b0;
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("rst_leds", leds(), LED_CMD);
    check_eq("rst_tx", uart_tx_data, 1'b1);
    check_eq("rst_dot", data_out_test, 8'h00);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    send_byte(8'h55, 1'b1);
    check_eq("cmd_ignore_leds", leds(), LED_CMD);
    check_eq("cmd_ignore_dot", data_out_test, dot(8'h55));
    send_byte(8'h01, 1'b1);
    check_eq("cmd_go_leds", leds(), LED_KEY);

    send_byte(key_bytes[0], 1'b1);
    send_byte(key_bytes[1], 1'b1);
    rxv0 = rxv_cnt;
    send_byte(8'hA5, 1'b0);
    repeat (CLKS) @(negedge clk);
    check_eq("ferr_rxv", rxv_cnt - rxv0, 0);
    check_eq("ferr_dot", data_out_test, dot(8'h01));
    for (int i = 2; i < 7; i++) send_byte(key_bytes[i], 1'b1);
    check_eq("key_hold_leds", leds(), LED_KEY);
    send_byte(key_bytes[7], 1'b1);
    check_eq("key_done_leds", leds(), LED_TEXT);
    check_eq("key_dot", data_out_test, dot(8'h19));

    rxv0 = rxv_cnt;
    rx_line = 1'b0;
    repeat (5) @(negedge clk);
    rx_line = 1'b1;
    repeat (2 * CLKS) @(negedge clk);
    check_eq("glitch_rxv", rxv_cnt - rxv0, 0);
    check_eq("glitch_leds", leds(), LED_TEXT);

    base = tx_q.size();
    fb   = fall_q.size();
    for (int i = 0; i < 4; i++) send_byte(text_bytes[i], 1'b1);
    check_eq("enc_leds", leds(), LED_ENC);
    wait_tx(base, 1);
    check_eq("send_leds", leds(), LED_SEND);
    wait_tx(base, 4);
    check_ct(base);
    lat = (fall_q.size() > fb) ? fall_q[fb] - last_rxv : 999;
    check_eq("enc_latency_le34", (lat > 0 && lat <= 34), 1);
    repeat (CLKS) @(negedge clk);
    check_eq("back_cmd_leds", leds(), LED_CMD);

    run_txn();
    check_eq("rst_enc_pre_leds", leds(), LED_ENC);
    fb = fall_q.size();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check_eq("rst_enc_leds", leds(), LED_CMD);
    check_eq("rst_enc_tx", uart_tx_data, 1'b1);
    repeat (12 * CLKS) @(negedge clk);
    check_eq("rst_enc_no_tx", fall_q.size() - fb, 0);
    check_eq("rst_enc_leds2", leds(), LED_CMD);
    check_eq("rst_enc_dot", data_out_test, 8'h00);

    base = tx_q.size();
    run_txn();
    wait_tx(base, 4);
    check_ct(base);
    repeat (CLKS) @(negedge clk);
    check_eq("rerun_cmd_leds", leds(), LED_CMD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
